treeval_mc_controller: RTL and testbench
========================================

TREEVAL_MC_CONTROLLER -- requirements
Module: treeval_mc_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- W_MSG 64: message width.
- N_UNITS 4: execution units managed.
- W_ADDR 8: node address width.
- MAX_DATA_WIDTH 16: node data width.
- MAX_CONFIG_WIDTH 16: config data width.
- W_REWARD 10: expectation width.
- W_ACTION 3: action width.
- TIMEOUT 4096: cycles allowed per run.
- W_UID = clog2(N_UNITS), derived.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- in_valid in 1: command offered.
- in_ready out 1: command accepted when in_valid && in_ready.
- in_msg in W_MSG: command.
- out_valid out 1: response offered.
- out_ready in 1: response consumed when out_valid && out_ready.
- out_msg out W_MSG: response.
- eu_rst, eu_mem_par, eu_mem_rew, eu_mem_act, eu_mem_weight, eu_conf_nodes out N_UNITS each: per-unit one-cycle strobes.
- eu_mem_addr out W_ADDR: shared node address.
- eu_mem_data out MAX_DATA_WIDTH: shared node data.
- eu_conf_data out MAX_CONFIG_WIDTH: shared config data.
- eu_exp_change in N_UNITS: per-unit expectation-change flags.
- eu_exp in N_UNITS*W_REWARD: signed expectations, unit u at slice u.
- eu_act in N_UNITS*W_ACTION: actions, unit u at slice u.

Function
REQ-003 Command layout: [W_MSG-1:W_MSG-2] cmd (0 RUN, 1 SET_NODE, 2 SET_CONFIG, 3 STATUS); next W_UID bits unit id u; remainder is payload.
REQ-004 SET_NODE payload: addr in the top W_ADDR bits, then 2-bit subcmd (0 PARENT, 1 ACTION, 2 REWARD, 3 WEIGHT); data in the LSBs.
REQ-005 SET_CONFIG payload: top 2 bits subcmd (0 NODES, others ignored); data in the LSBs.
REQ-006 A command accepted at cycle t drives its strobe on unit u for exactly cycle t+1; addr/data buses hold their value until the next write.
REQ-007 Each unit has state IDLE, ARMED or RUNNING.
- RUN to an IDLE unit: pulse eu_rst[u]; state goes to ARMED and the timeout counter clears.
- ARMED to RUNNING: on the first eu_exp_change[u] high.
- RUNNING to IDLE: on a later eu_exp_change[u] high; set result_pending[u] with a RESULT response.
- ARMED or RUNNING to IDLE when the counter reaches TIMEOUT: set result_pending[u] with a TIMEOUT response.
REQ-008 RUN, SET_NODE or SET_CONFIG to a non-IDLE unit, or u >= N_UNITS, issues no strobe and produces an immediate BUSY_ERR response.
REQ-009 STATUS produces an immediate STATUS response whose LSBs hold the N_UNITS busy mask (bit u = unit u not IDLE).
REQ-010 Response layout: [W_MSG-1:W_MSG-2] type (0 RESULT, 1 TIMEOUT, 2 BUSY_ERR, 3 STATUS); next W_UID bits unit id; for RESULT, LSBs = {act, exp}, zero-extended; for TIMEOUT and BUSY_ERR, LSBs are zero.
REQ-011 A single registered output slot holds one response.
- out_msg and out_valid stay stable until out_ready.
- When the slot is empty or being consumed, it loads the immediate response first, otherwise the round-robin winner among result_pending, starting after the last served unit.
REQ-012 in_ready is low while an immediate response is waiting for the slot; no command is ever dropped.
REQ-013 RESULT captures eu_exp/eu_act on the completion cycle. A unit may be restarted while its result is still pending, and the pending result is kept.
REQ-014 Completion and timeout on the same cycle: RESULT wins.

Reset
REQ-015 While rst is high:
- out_valid = 0, in_ready = 0.
- All eu_* strobes are 0 and eu_rst is all-ones.
- All units are IDLE; all pending flags, counters and the round-robin pointer are 0.
REQ-016 Reset mid-run discards in-flight results; the first command is accepted one cycle after rst falls.

Structure
REQ-017 The package treeval_pkg holds the cmd, subcmd and response-type enums, the field-offset functions, and the default widths.
REQ-018 A per-unit tracker sub-module treeval_unit_tracker (state, timeout counter, result capture) is instantiated N_UNITS times.

Verification
REQ-019 Cover these directed scenarios:
- SET_NODE PARENT u=2 addr=5 data=0x1234 -> eu_mem_par = 4'b0100 for one cycle; eu_mem_addr = 5; eu_mem_data = 0x1234.
- RUN u=1; eu_exp_change[1] pulses twice with eu_exp[1] = -3 and eu_act[1] = 6 -> RESULT, unit 1, LSBs {3'd6, 10'h3FD}.
- RUN u=0; no eu_exp_change for TIMEOUT cycles -> TIMEOUT, unit 0; STATUS then returns mask 0.
- RUN u=3 twice -> second command gets BUSY_ERR, unit 3, with no second eu_rst pulse.
- Units 0 and 2 complete on the same cycle with out_ready held low 10 cycles -> both results delivered, unit 0 then unit 2, no loss.
- rst asserted while unit 1 is RUNNING -> no response ever appears; STATUS after reset returns mask 0.

Source files
------------

// File: rtl/treeval_pkg.sv
// Shared types and field helpers for the tree-evaluation multi-unit controller.
// Command/response fields are packed MSB-first: 2-bit opcode, unit id, then payload.
package treeval_pkg;

  localparam int DEF_W_MSG            = 64;
  localparam int DEF_N_UNITS          = 4;
  localparam int DEF_W_ADDR           = 8;
  localparam int DEF_MAX_DATA_WIDTH   = 16;
  localparam int DEF_MAX_CONFIG_WIDTH = 16;
  localparam int DEF_W_REWARD         = 10;
  localparam int DEF_W_ACTION         = 3;
  localparam int DEF_TIMEOUT          = 4096;

  typedef enum logic [1:0] {
    CMD_RUN        = 2'd0,
    CMD_SET_NODE   = 2'd1,
    CMD_SET_CONFIG = 2'd2,
    CMD_STATUS     = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    SUB_PARENT = 2'd0,
    SUB_ACTION = 2'd1,
    SUB_REWARD = 2'd2,
    SUB_WEIGHT = 2'd3
  } node_sub_e;

  typedef enum logic [1:0] {
    CFG_NODES = 2'd0,
    CFG_RSVD1 = 2'd1,
    CFG_RSVD2 = 2'd2,
    CFG_RSVD3 = 2'd3
  } cfg_sub_e;

  typedef enum logic [1:0] {
    RSP_RESULT   = 2'd0,
    RSP_TIMEOUT  = 2'd1,
    RSP_BUSY_ERR = 2'd2,
    RSP_STATUS   = 2'd3
  } rsp_e;

  typedef enum logic [1:0] {
    U_IDLE    = 2'd0,
    U_ARMED   = 2'd1,
    U_RUNNING = 2'd2
  } unit_state_e;

  // A single unit still needs a 1-bit id field.
  function automatic int uid_width(input int n_units);
    return (n_units > 1) ? $clog2(n_units) : 1;
  endfunction

  function automatic int uid_lo(input int w_msg, input int w_uid);
    return w_msg - 2 - w_uid;
  endfunction

  function automatic int addr_lo(input int w_msg, input int w_uid, input int w_addr);
    return uid_lo(w_msg, w_uid) - w_addr;
  endfunction

  function automatic int node_sub_lo(input int w_msg, input int w_uid, input int w_addr);
    return addr_lo(w_msg, w_uid, w_addr) - 2;
  endfunction

  function automatic int cfg_sub_lo(input int w_msg, input int w_uid);
    return uid_lo(w_msg, w_uid) - 2;
  endfunction

endpackage

// File: rtl/treeval_unit_tracker.sv
// Per-unit run tracker: IDLE/ARMED/RUNNING state, timeout counter and a
// one-deep pending result that survives a restart until it is served.
module treeval_unit_tracker
  import treeval_pkg::*;
#(
  parameter int W_REWARD = DEF_W_REWARD,
  parameter int W_ACTION = DEF_W_ACTION,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                exp_change,
  input  logic                clear,
  input  logic [W_REWARD-1:0] exp_val,
  input  logic [W_ACTION-1:0] act_val,
  output unit_state_e         state,
  output logic                pending,
  output logic                pend_timeout,
  output logic [W_REWARD-1:0] pend_exp,
  output logic [W_ACTION-1:0] pend_act
);

  localparam int W_CNT = $clog2(TIMEOUT + 1);

  unit_state_e         state_q, state_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;
  logic                finish, timed_out;
  logic                pend_q, pend_to_q;
  logic [W_REWARD-1:0] pend_exp_q;
  logic [W_ACTION-1:0] pend_act_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (start) begin
          state_d = U_ARMED;
          cnt_d   = '0;
        end
      end
      U_ARMED, U_RUNNING: begin
        // Completion is checked before the timeout so it wins a tie.
        if (state_q == U_RUNNING && exp_change) begin
          finish  = 1'b1;
          state_d = U_IDLE;
        end else if (cnt_q == W_CNT'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_d   = U_IDLE;
        end else begin
          cnt_d = cnt_q + W_CNT'(1);
          if (exp_change) state_d = U_RUNNING;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= U_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_to_q  <= 1'b0;
      pend_exp_q <= '0;
      pend_act_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // An older unserved result is kept; a new one lands once the slot frees.
      if ((finish || timed_out) && (!pend_q || clear)) begin
        pend_q     <= 1'b1;
        pend_to_q  <= timed_out;
        pend_exp_q <= finish ? exp_val : '0;
        pend_act_q <= finish ? act_val : '0;
      end else if (clear) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign state        = state_q;
  assign pending      = pend_q;
  assign pend_timeout = pend_to_q;
  assign pend_exp     = pend_exp_q;
  assign pend_act     = pend_act_q;

endmodule

// File: rtl/treeval_mc_controller.sv
// Multi-unit controller: decodes commands into per-unit strobes, tracks each
// unit's run, and serialises results through a single registered response slot.
module treeval_mc_controller
  import treeval_pkg::*;
#(
  parameter int W_MSG            = DEF_W_MSG,
  parameter int N_UNITS          = DEF_N_UNITS,
  parameter int W_ADDR           = DEF_W_ADDR,
  parameter int MAX_DATA_WIDTH   = DEF_MAX_DATA_WIDTH,
  parameter int MAX_CONFIG_WIDTH = DEF_MAX_CONFIG_WIDTH,
  parameter int W_REWARD         = DEF_W_REWARD,
  parameter int W_ACTION         = DEF_W_ACTION,
  parameter int TIMEOUT          = DEF_TIMEOUT,
  parameter int W_UID            = uid_width(N_UNITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W_MSG-1:0]              in_msg,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W_MSG-1:0]              out_msg,
  output logic [N_UNITS-1:0]            eu_rst,
  output logic [N_UNITS-1:0]            eu_mem_par,
  output logic [N_UNITS-1:0]            eu_mem_rew,
  output logic [N_UNITS-1:0]            eu_mem_act,
  output logic [N_UNITS-1:0]            eu_mem_weight,
  output logic [N_UNITS-1:0]            eu_conf_nodes,
  output logic [W_ADDR-1:0]             eu_mem_addr,
  output logic [MAX_DATA_WIDTH-1:0]     eu_mem_data,
  output logic [MAX_CONFIG_WIDTH-1:0]   eu_conf_data,
  input  logic [N_UNITS-1:0]            eu_exp_change,
  input  logic [N_UNITS*W_REWARD-1:0]   eu_exp,
  input  logic [N_UNITS*W_ACTION-1:0]   eu_act
);

  localparam int UID_LO  = uid_lo(W_MSG, W_UID);
  localparam int ADDR_LO = addr_lo(W_MSG, W_UID, W_ADDR);
  localparam int NSUB_LO = node_sub_lo(W_MSG, W_UID, W_ADDR);
  localparam int CSUB_LO = cfg_sub_lo(W_MSG, W_UID);
  localparam int W_RES   = W_ACTION + W_REWARD;

  // Both ports use valid/ready: a transfer happens on a cycle where valid and
  // ready are both high; the sender holds valid and its payload until then.

  function automatic logic [W_MSG-1:0] build_rsp(input rsp_e t,
                                                 input logic [W_UID-1:0] id,
                                                 input logic [W_MSG-1:0] lsb);
    logic [W_MSG-1:0] m;
    m                  = lsb;
    m[W_MSG-1 -: 2]    = t;
    m[UID_LO +: W_UID] = id;
    return m;
  endfunction

  // Command field decode
  cmd_e                 cmd;
  node_sub_e            node_sub;
  cfg_sub_e             cfg_sub;
  logic [W_UID-1:0]     uid;
  logic [N_UNITS-1:0]   uid_onehot;
  logic                 uid_ok, unit_busy, accept;
  logic                 unused_msg;

  assign cmd        = cmd_e'(in_msg[W_MSG-1 -: 2]);
  assign uid        = in_msg[UID_LO +: W_UID];
  assign node_sub   = node_sub_e'(in_msg[NSUB_LO +: 2]);
  assign cfg_sub    = cfg_sub_e'(in_msg[CSUB_LO +: 2]);
  assign uid_ok     = int'(uid) < N_UNITS;
  assign uid_onehot = N_UNITS'(1) << uid;
  assign accept     = in_valid && in_ready;
  assign unused_msg = ^in_msg;

  // Per-unit trackers
  unit_state_e          unit_state [N_UNITS];
  logic [N_UNITS-1:0]   busy, pending, pend_to, start_vec, clear_vec;
  logic [W_REWARD-1:0]  pend_exp [N_UNITS];
  logic [W_ACTION-1:0]  pend_act [N_UNITS];

  for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
    treeval_unit_tracker #(
      .W_REWARD (W_REWARD),
      .W_ACTION (W_ACTION),
      .TIMEOUT  (TIMEOUT)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .start        (start_vec[u]),
      .exp_change   (eu_exp_change[u]),
      .clear        (clear_vec[u]),
      .exp_val      (eu_exp[u*W_REWARD +: W_REWARD]),
      .act_val      (eu_act[u*W_ACTION +: W_ACTION]),
      .state        (unit_state[u]),
      .pending      (pending[u]),
      .pend_timeout (pend_to[u]),
      .pend_exp     (pend_exp[u]),
      .pend_act     (pend_act[u])
    );
    assign busy[u] = (unit_state[u] != U_IDLE);
  end

  assign unit_busy = uid_ok ? busy[uid] : 1'b1;

  // Command dispatch: strobes and the immediate response register next cycle
  logic [N_UNITS-1:0] par_d, act_d, rew_d, wgt_d, conf_d;
  logic               wr_node, wr_cfg, imm_d_valid;
  logic [W_MSG-1:0]   imm_d_msg;

  always_comb begin
    start_vec   = '0;
    par_d       = '0;
    act_d       = '0;
    rew_d       = '0;
    wgt_d       = '0;
    conf_d      = '0;
    wr_node     = 1'b0;
    wr_cfg      = 1'b0;
    imm_d_valid = 1'b0;
    imm_d_msg   = '0;
    if (accept) begin
      if (cmd == CMD_STATUS) begin
        imm_d_valid = 1'b1;
        imm_d_msg   = build_rsp(RSP_STATUS, uid, W_MSG'(busy));
      end else if (unit_busy) begin
        imm_d_valid = 1'b1;
        imm_d_msg   = build_rsp(RSP_BUSY_ERR, uid, '0);
      end else begin
        case (cmd)
          CMD_RUN: start_vec = uid_onehot;
          CMD_SET_NODE: begin
            wr_node = 1'b1;
            case (node_sub)
              SUB_PARENT: par_d = uid_onehot;
              SUB_ACTION: act_d = uid_onehot;
              SUB_REWARD: rew_d = uid_onehot;
              SUB_WEIGHT: wgt_d = uid_onehot;
              default:    par_d = '0;
            endcase
          end
          CMD_SET_CONFIG: begin
            if (cfg_sub == CFG_NODES) begin
              wr_cfg = 1'b1;
              conf_d = uid_onehot;
            end
          end
          default: start_vec = '0;
        endcase
      end
    end
  end

  // Round-robin pick over pending results, starting at rr_ptr
  logic               imm_valid, out_valid_q, run_en, slot_free, rr_found;
  logic [W_MSG-1:0]   imm_msg, out_msg_q, res_msg;
  logic [W_UID-1:0]   rr_ptr, rr_idx;
  logic [W_RES-1:0]   res_lsb;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    int k;
    k         = 0;
    rr_found  = 1'b0;
    rr_idx    = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      k = (int'(rr_ptr) + i) % N_UNITS;
      if (!rr_found && pending[W_UID'(k)]) begin
        rr_found = 1'b1;
        rr_idx   = W_UID'(k);
      end
    end
  end

  always_comb begin
    clear_vec = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      clear_vec[u] = slot_free && !imm_valid && rr_found && (rr_idx == W_UID'(u));
    end
  end

  always_comb begin
    res_lsb = {pend_act[rr_idx], pend_exp[rr_idx]};
    if (pend_to[rr_idx]) res_msg = build_rsp(RSP_TIMEOUT, rr_idx, '0);
    else                 res_msg = build_rsp(RSP_RESULT, rr_idx, W_MSG'(res_lsb));
  end

  logic [N_UNITS-1:0]          rst_q, par_q, act_q, rew_q, wgt_q, conf_q;
  logic [W_ADDR-1:0]           addr_q;
  logic [MAX_DATA_WIDTH-1:0]   data_q;
  logic [MAX_CONFIG_WIDTH-1:0] conf_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_en      <= 1'b0;
      rst_q       <= '0;
      par_q       <= '0;
      act_q       <= '0;
      rew_q       <= '0;
      wgt_q       <= '0;
      conf_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      conf_data_q <= '0;
      imm_valid   <= 1'b0;
      imm_msg     <= '0;
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
      rr_ptr      <= '0;
    end else begin
      run_en <= 1'b1;
      rst_q  <= start_vec;
      par_q  <= par_d;
      act_q  <= act_d;
      rew_q  <= rew_d;
      wgt_q  <= wgt_d;
      conf_q <= conf_d;
      if (wr_node) begin
        addr_q <= in_msg[ADDR_LO +: W_ADDR];
        data_q <= in_msg[MAX_DATA_WIDTH-1:0];
      end
      if (wr_cfg) conf_data_q <= in_msg[MAX_CONFIG_WIDTH-1:0];

      // accept needs !imm_valid, so a new immediate never collides with a drain
      if (imm_d_valid) begin
        imm_valid <= 1'b1;
        imm_msg   <= imm_d_msg;
      end else if (slot_free && imm_valid) begin
        imm_valid <= 1'b0;
      end

      if (slot_free) begin
        if (imm_valid) begin
          out_valid_q <= 1'b1;
          out_msg_q   <= imm_msg;
        end else if (rr_found) begin
          out_valid_q <= 1'b1;
          out_msg_q   <= res_msg;
          rr_ptr      <= (int'(rr_idx) == N_UNITS - 1) ? '0 : rr_idx + 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign in_ready      = run_en && !imm_valid && !rst;
  assign out_valid     = out_valid_q && !rst;
  assign out_msg       = out_msg_q;
  assign eu_rst        = rst ? '1 : rst_q;
  assign eu_mem_par    = rst ? '0 : par_q;
  assign eu_mem_act    = rst ? '0 : act_q;
  assign eu_mem_rew    = rst ? '0 : rew_q;
  assign eu_mem_weight = rst ? '0 : wgt_q;
  assign eu_conf_nodes = rst ? '0 : conf_q;
  assign eu_mem_addr   = addr_q;
  assign eu_mem_data   = data_q;
  assign eu_conf_data  = conf_data_q;

endmodule

// File: tb/tb_treeval_mc_controller.sv
// Directed bench for treeval_mc_controller: strobe decode, run completion,
// timeout, busy errors, reset discard and round-robin result ordering.
module tb_treeval_mc_controller;

  localparam int W_MSG = 64, N_UNITS = 4, W_ADDR = 8, MAX_DATA_WIDTH = 16;
  localparam int MAX_CONFIG_WIDTH = 16, W_REWARD = 10, W_ACTION = 3, TIMEOUT = 4096;

  logic                        clk, rst;
  logic                        in_valid, in_ready, out_valid, out_ready;
  logic [W_MSG-1:0]            in_msg, out_msg;
  logic [N_UNITS-1:0]          eu_rst, eu_mem_par, eu_mem_rew, eu_mem_act, eu_mem_weight, eu_conf_nodes;
  logic [W_ADDR-1:0]           eu_mem_addr;
  logic [MAX_DATA_WIDTH-1:0]   eu_mem_data;
  logic [MAX_CONFIG_WIDTH-1:0] eu_conf_data;
  logic [N_UNITS-1:0]          eu_exp_change;
  logic [N_UNITS*W_REWARD-1:0] eu_exp;
  logic [N_UNITS*W_ACTION-1:0] eu_act;

  int n_checks = 0;
  int n_errors = 0;
  logic [W_MSG-1:0] exp_q[$];

  treeval_mc_controller #(
    .W_MSG(W_MSG), .N_UNITS(N_UNITS), .W_ADDR(W_ADDR), .MAX_DATA_WIDTH(MAX_DATA_WIDTH),
    .MAX_CONFIG_WIDTH(MAX_CONFIG_WIDTH), .W_REWARD(W_REWARD), .W_ACTION(W_ACTION), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .eu_rst(eu_rst), .eu_mem_par(eu_mem_par), .eu_mem_rew(eu_mem_rew), .eu_mem_act(eu_mem_act),
    .eu_mem_weight(eu_mem_weight), .eu_conf_nodes(eu_conf_nodes), .eu_mem_addr(eu_mem_addr),
    .eu_mem_data(eu_mem_data), .eu_conf_data(eu_conf_data), .eu_exp_change(eu_exp_change),
    .eu_exp(eu_exp), .eu_act(eu_act)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every consumed response is compared with the head of exp_q
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {63'b0, out_valid}, 64'd0);
      else                   check("rsp_msg", out_msg, exp_q.pop_front());
    end
  end

  // Driver tasks (entered and left #1 after a rising edge)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] mk_cmd(input logic [1:0] c, input logic [1:0] u, input logic [59:0] pl);
    return {c, u, pl};
  endfunction

  function automatic logic [63:0] mk_node(input logic [1:0] u, input logic [7:0] a,
                                          input logic [1:0] sub, input logic [15:0] d);
    return mk_cmd(2'd1, u, {a, sub, 34'b0, d});
  endfunction

  function automatic logic [63:0] mk_cfg(input logic [1:0] u, input logic [1:0] sub, input logic [15:0] d);
    return mk_cmd(2'd2, u, {sub, 42'b0, d});
  endfunction

  task automatic send_cmd(input logic [63:0] m);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_msg   = m;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_exp(input logic [N_UNITS-1:0] mask);
    eu_exp_change = mask;
    tick(1);
    eu_exp_change = '0;
  endtask

  task automatic check_strobes(input string tag, input logic [3:0] r, input logic [3:0] par,
                               input logic [3:0] act, input logic [3:0] rew,
                               input logic [3:0] wgt, input logic [3:0] conf);
    check({tag, "_rst"}, eu_rst, r);
    check({tag, "_par"}, eu_mem_par, par);
    check({tag, "_act"}, eu_mem_act, act);
    check({tag, "_rew"}, eu_mem_rew, rew);
    check({tag, "_wgt"}, eu_mem_weight, wgt);
    check({tag, "_conf"}, eu_conf_nodes, conf);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_msg = '0; out_ready = 1'b1;
    eu_exp_change = '0; eu_exp = '0; eu_act = '0;

    // Reset state
    tick(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check_strobes("rst", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready0", in_ready, 0);
    check("post_rst_eu_rst", eu_rst, 4'h0);
    tick(1);
    check("post_rst_in_ready1", in_ready, 1);

    // Node / config writes
    send_cmd(mk_node(2'd2, 8'd5, 2'd0, 16'h1234));
    check_strobes("par_u2", 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0);
    check("par_addr", eu_mem_addr, 8'd5);
    check("par_data", eu_mem_data, 16'h1234);
    tick(1);
    check("par_off", eu_mem_par, 4'h0);
    check("par_addr_hold", eu_mem_addr, 8'd5);
    send_cmd(mk_node(2'd0, 8'hAB, 2'd3, 16'hBEEF));
    check_strobes("wgt_u0", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0);
    check("wgt_addr", eu_mem_addr, 8'hAB);
    check("wgt_data", eu_mem_data, 16'hBEEF);
    send_cmd(mk_node(2'd1, 8'd7, 2'd2, 16'h0042));
    check_strobes("rew_u1", 4'h0, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0);
    send_cmd(mk_node(2'd3, 8'd9, 2'd1, 16'h0077));
    check_strobes("act_u3", 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 4'h0);
    send_cmd(mk_cfg(2'd3, 2'd0, 16'h00C3));
    check_strobes("conf_u3", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000);
    check("conf_data", eu_conf_data, 16'h00C3);
    check("addr_hold_cfg", eu_mem_addr, 8'd9);
    send_cmd(mk_cfg(2'd3, 2'd1, 16'h0055));
    check_strobes("cfg_ignored", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("conf_data_hold", eu_conf_data, 16'h00C3);

    // Run to completion on unit 1, STATUS while running
    send_cmd(mk_cmd(2'd0, 2'd1, '0));
    check_strobes("run_u1", 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check("run_u1_rst_off", eu_rst, 4'h0);
    eu_exp[1*W_REWARD +: W_REWARD] = 10'd5;
    eu_act[1*W_ACTION +: W_ACTION] = 3'd1;
    pulse_exp(4'b0010);
    tick(3);
    exp_q.push_back(64'hC000_0000_0000_0002);
    send_cmd(mk_cmd(2'd3, 2'd0, '0));
    wait_drain(20);
    eu_exp[1*W_REWARD +: W_REWARD] = 10'h3FD;
    eu_act[1*W_ACTION +: W_ACTION] = 3'd6;
    exp_q.push_back(64'h1000_0000_0000_1BFD);
    pulse_exp(4'b0010);
    eu_exp = '0;
    eu_act = '0;
    wait_drain(20);

    // Timeout on unit 0
    exp_q.push_back(64'h4000_0000_0000_0000);
    send_cmd(mk_cmd(2'd0, 2'd0, '0));
    n = 0;
    while (!out_valid && n < TIMEOUT + 20) begin
      tick(1);
      n++;
    end
    check("timeout_window", {63'b0, (n >= TIMEOUT - 1) && (n <= TIMEOUT + 2)}, 64'd1);
    wait_drain(20);
    exp_q.push_back(64'hC000_0000_0000_0000);
    send_cmd(mk_cmd(2'd3, 2'd0, '0));
    wait_drain(20);

    // Second RUN / SET_NODE to an armed unit are rejected
    send_cmd(mk_cmd(2'd0, 2'd3, '0));
    check_strobes("run_u3", 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    exp_q.push_back(64'hB000_0000_0000_0000);
    send_cmd(mk_cmd(2'd0, 2'd3, '0));
    check_strobes("run_u3_busy", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    exp_q.push_back(64'hB000_0000_0000_0000);
    send_cmd(mk_node(2'd3, 8'd33, 2'd0, 16'h0001));
    check_strobes("node_u3_busy", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("busy_addr_hold", eu_mem_addr, 8'd9);
    wait_drain(20);

    // Reset while unit 1 is running discards everything
    send_cmd(mk_cmd(2'd0, 2'd1, '0));
    check_strobes("run_u1b", 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    pulse_exp(4'b0010);
    exp_q.push_back(64'hC000_0000_0000_000A);
    send_cmd(mk_cmd(2'd3, 2'd0, '0));
    wait_drain(20);
    rst = 1'b1;
    tick(2);
    check("midrst_eu_rst", eu_rst, 4'hF);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick(1);
    pulse_exp(4'b1010);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (out_valid) n++;
    end
    check("midrst_no_rsp", n, 0);
    exp_q.push_back(64'hC000_0000_0000_0000);
    send_cmd(mk_cmd(2'd3, 2'd1, '0) & ~64'h3000_0000_0000_0000);
    wait_drain(20);

    // Units 0 and 2 complete together while the sink stalls
    send_cmd(mk_cmd(2'd0, 2'd0, '0));
    check_strobes("run_u0", 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    send_cmd(mk_cmd(2'd0, 2'd2, '0));
    check_strobes("run_u2", 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    pulse_exp(4'b0101);
    tick(2);
    eu_exp[0*W_REWARD +: W_REWARD] = 10'd100;
    eu_act[0*W_ACTION +: W_ACTION] = 3'd2;
    eu_exp[2*W_REWARD +: W_REWARD] = 10'h3FF;
    eu_act[2*W_ACTION +: W_ACTION] = 3'd7;
    out_ready = 1'b0;
    exp_q.push_back(64'h0000_0000_0000_0864);
    pulse_exp(4'b0101);
    eu_exp = '0;
    eu_act = '0;
    tick(1);
    exp_q.push_back(64'hC000_0000_0000_0000);
    send_cmd(mk_cmd(2'd3, 2'd0, '0));
    check("imm_blocks_in_ready", in_ready, 0);
    exp_q.push_back(64'h2000_0000_0000_1FFF);
    tick(7);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_msg", out_msg, 64'h0000_0000_0000_0864);
    out_ready = 1'b1;
    wait_drain(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
